// File: rtl/sint_cmp_pkg.sv
// rtl/sint_cmp_pkg.sv - compare opcode type and constants shared by the compare pipeline
package sint_cmp_pkg;

  typedef logic [2:0] cmp_op_t;

  localparam cmp_op_t CMP_EQ     = 3'd0;
  localparam cmp_op_t CMP_NE     = 3'd1;
  localparam cmp_op_t CMP_LT     = 3'd2;
  localparam cmp_op_t CMP_LE     = 3'd3;
  localparam cmp_op_t CMP_GT     = 3'd4;
  localparam cmp_op_t CMP_GE     = 3'd5;
  // Opcodes at or above this value are reserved and flag op_err.
  localparam cmp_op_t CMP_RSV_LO = 3'd6;

endpackage

// File: rtl/sint_cmp_core.sv
// rtl/sint_cmp_core.sv - combinational signed/unsigned compare of I0 op I1
module sint_cmp_core
  import sint_cmp_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  cmp_op_t          op,
  input  logic             is_signed,
  output logic             O,
  output logic             op_err
);

  logic eq;
  logic lt;

  always_comb begin
    eq     = (I0 == I1);
    lt     = is_signed ? ($signed(I0) < $signed(I1)) : (I0 < I1);
    op_err = (op >= CMP_RSV_LO);
    O      = 1'b0;
    case (op)
      CMP_EQ:  O = eq;
      CMP_NE:  O = !eq;
      CMP_LT:  O = lt;
      CMP_LE:  O = lt || eq;
      CMP_GT:  O = !(lt || eq);
      CMP_GE:  O = !lt;
      default: O = 1'b0;
    endcase
  end

endmodule

// File: rtl/sint_cmp_pipe.sv
// rtl/sint_cmp_pipe.sv - two-stage valid/ready compare pipeline with saturating true-result counter
module sint_cmp_pipe
  import sint_cmp_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     I0,
  input  logic [WIDTH-1:0]     I1,
  input  logic [2:0]           op,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 O,
  output logic                 op_err,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] true_count,
  output logic                 cnt_sat
);

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_i0_q, s1_i1_q;
  cmp_op_t              s1_op_q;
  logic                 s1_signed_q;
  logic                 s2_valid_q, s2_valid_d;
  logic                 o_q, o_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 s2_ready, s1_advance, s1_load;
  logic                 core_o, core_err;

  sint_cmp_core #(.WIDTH(WIDTH)) u_core (
    .I0        (s1_i0_q),
    .I1        (s1_i1_q),
    .op        (s1_op_q),
    .is_signed (s1_signed_q),
    .O         (core_o),
    .op_err    (core_err)
  );

  always_comb begin
    s2_ready   = !s2_valid_q || out_ready;
    s1_advance = s1_valid_q && s2_ready;
    in_ready   = !s1_valid_q || s1_advance;
    s1_load    = in_valid && in_ready;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
    o_d        = s1_advance ? core_o : o_q;
    err_d      = s1_advance ? core_err : err_q;
    cnt_d      = cnt_q;
    // Clear wins over a same-cycle increment; counter sticks at all-ones.
    if (clear) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready && o_q && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      o_q        <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      o_q        <= o_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Operand registers are qualified by s1_valid_q, so they need no reset.
  always_ff @(posedge CLK) begin
    if (s1_load) begin
      s1_i0_q     <= I0;
      s1_i1_q     <= I1;
      s1_op_q     <= op;
      s1_signed_q <= is_signed;
    end
  end

  assign out_valid  = s2_valid_q;
  assign O          = o_q;
  assign op_err     = err_q;
  assign true_count = cnt_q;
  assign cnt_sat    = &cnt_q;

endmodule

// File: tb/tb_sint_cmp_pipe.sv
// tb/tb_sint_cmp_pipe.sv - directed self-checking bench for sint_cmp_pipe (WIDTH=3, CNT_WIDTH=2)
module tb_sint_cmp_pipe;

  logic       CLK = 1'b0;
  logic       ASYNCRESET;
  logic       in_valid, in_ready;
  logic [2:0] I0, I1, op;
  logic       is_signed;
  logic       out_valid, out_ready;
  logic       O, op_err;
  logic       clear;
  logic [1:0] true_count;
  logic       cnt_sat;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] bp_i0  [4] = '{3'd2, 3'd5, 3'd1, 3'd1};
  logic [2:0] bp_i1  [4] = '{3'd2, 3'd2, 3'd6, 3'd1};
  logic [2:0] bp_op  [4] = '{3'd0, 3'd2, 3'd4, 3'd1};
  logic       bp_sgn [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic       bp_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  sint_cmp_pipe #(.WIDTH(3), .CNT_WIDTH(2)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .I0         (I0),
    .I1         (I1),
    .op         (op),
    .is_signed  (is_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .O          (O),
    .op_err     (op_err),
    .clear      (clear),
    .true_count (true_count),
    .cnt_sat    (cnt_sat)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic one_beat(input string tag, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] opc, input logic sgn, input logic exp_o,
                          input logic exp_err, input logic clr, input logic [1:0] exp_cnt,
                          input logic exp_sat);
    I0 = a; I1 = b; op = opc; is_signed = sgn;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    #1 check_eq({tag, "_lat1_ov"}, out_valid, 1'b0);
    @(posedge CLK); #1;
    clear = clr;
    #1;
    check_eq({tag, "_ov"}, out_valid, 1'b1);
    check_eq({tag, "_o"}, O, exp_o);
    check_eq({tag, "_err"}, op_err, exp_err);
    @(posedge CLK); #1;
    clear = 1'b0;
    #1;
    check_eq({tag, "_ov_done"}, out_valid, 1'b0);
    check_eq({tag, "_cnt"}, true_count, exp_cnt);
    check_eq({tag, "_sat"}, cnt_sat, exp_sat);
  endtask

  initial begin
    ASYNCRESET = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    I0 = '0; I1 = '0; op = '0; is_signed = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_ov", out_valid, 1'b0);
    check_eq("rst_o", O, 1'b0);
    check_eq("rst_err", op_err, 1'b0);
    check_eq("rst_cnt", true_count, 2'd0);
    check_eq("rst_sat", cnt_sat, 1'b0);
    ASYNCRESET = 1'b0;
    #1 check_eq("rst_in_ready", in_ready, 1'b1);
    @(posedge CLK); #1;

    one_beat("le_s",     3'b111, 3'b001, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    one_beat("le_u",     3'b111, 3'b001, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    one_beat("gt_s_ext", 3'b100, 3'b011, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    one_beat("ge_s_eq",  3'b100, 3'b100, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
    one_beat("rsv6",     3'b101, 3'b010, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);
    one_beat("lt_u",     3'b010, 3'b101, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1);
    one_beat("ne_eq",    3'b011, 3'b011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1);
    one_beat("lt_s",     3'b011, 3'b100, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1);
    one_beat("lt_u2",    3'b011, 3'b100, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1);
    one_beat("ge_u0",    3'b000, 3'b000, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1);
    one_beat("rsv7",     3'b111, 3'b111, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1);
    one_beat("eq_clr",   3'b001, 3'b001, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    one_beat("gt_u",     3'b100, 3'b011, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);

    begin : backpressure
      int  acc = 0;
      int  got = 0;
      int  first_ov = -1;
      int  stalls = 0;
      bit  seen_low = 1'b0;
      logic xfer, accepted;
      for (int c = 0; c < 30 && got < 4; c++) begin
        if (out_valid && first_ov < 0) first_ov = c;
        out_ready = (first_ov < 0) ? 1'b0 : (c >= first_ov + 3);
        in_valid  = (acc < 4);
        if (acc < 4) begin
          I0 = bp_i0[acc]; I1 = bp_i1[acc]; op = bp_op[acc]; is_signed = bp_sgn[acc];
        end
        #1;
        if (in_valid && !in_ready && !seen_low) begin
          seen_low = 1'b1;
          check_eq("bp_acc_at_stall", acc, 2);
        end
        if (out_valid) check_eq("bp_o", O, bp_exp[got]);
        if (out_valid && !out_ready) stalls++;
        xfer     = out_valid && out_ready;
        accepted = in_valid && in_ready;
        @(posedge CLK); #1;
        if (xfer) got++;
        if (accepted) acc++;
      end
      in_valid = 1'b0;
      check_eq("bp_delivered", got, 4);
      check_eq("bp_stall_seen", seen_low, 1'b1);
      check_eq("bp_stall_cycles", stalls, 3);
      check_eq("bp_cnt", true_count, 2'd3);
    end

    @(posedge CLK); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; I0 = 3'd0; I1 = 3'd0; op = 3'd0; is_signed = 1'b0;
    @(posedge CLK); #1;
    I0 = 3'd3; I1 = 3'd3;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    check_eq("mrst_ov_before", out_valid, 1'b1);
    ASYNCRESET = 1'b1;
    #1;
    check_eq("mrst_ov", out_valid, 1'b0);
    check_eq("mrst_o", O, 1'b0);
    check_eq("mrst_cnt", true_count, 2'd0);
    check_eq("mrst_sat", cnt_sat, 1'b0);
    @(posedge CLK); #1;
    ASYNCRESET = 1'b0;
    out_ready = 1'b1;
    #1 check_eq("mrst_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      check_eq("mrst_no_stale", out_valid, 1'b0);
    end
    check_eq("mrst_cnt_after", true_count, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sint_cmp_pipe.md
SINT_CMP_PIPE -- requirements
Module: sint_cmp_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 3, operand width in bits (WIDTH >= 1).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the true-result counter (CNT_WIDTH >= 1).
REQ-003 SHALL have ports CLK input 1, the single clock, rising-edge.
REQ-004 SHALL have ports ASYNCRESET input 1, asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 (operand beat offered) and in_ready output 1 (beat accepted when both high).
REQ-006 SHALL have ports I0 input WIDTH and I1 input WIDTH, the operands.
REQ-007 SHALL have ports op input 3 (compare opcode) and is_signed input 1 (1 = two's-complement, 0 = unsigned).
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1, the result handshake.
REQ-009 SHALL have ports O output 1 (compare result) and op_err output 1 (result came from a reserved opcode).
REQ-010 SHALL have ports clear input 1 (synchronous counter clear), true_count output CNT_WIDTH, and cnt_sat output 1 (counter saturated).

Function
REQ-011 SHALL use opcodes 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE; I0 is the left operand (I0 op I1).
REQ-012 SHALL treat opcodes 6 and 7 as reserved: O=0, op_err=1 on that result; the beat is otherwise a normal transfer.
REQ-013 SHALL compare as signed when is_signed=1 (MSB is sign) and as unsigned when 0; EQ/NE are independent of is_signed.
REQ-014 SHALL be a two-stage pipeline: stage 1 registers I0, I1, op, is_signed; stage 2 registers O and op_err; latency is 2 cycles from accepted input to out_valid with no back-pressure.
REQ-015 SHALL advance each stage when it is empty or its downstream stage accepts in the same cycle; in_ready = !s1_valid || s1_advance, combinationally dependent on out_ready.
REQ-016 SHALL sustain one beat per cycle with out_ready held high.
REQ-017 SHALL hold O, op_err and out_valid stable while out_valid=1 and out_ready=0; no beat is lost or duplicated under any ready pattern.
REQ-018 SHALL increment true_count by 1 on each output transfer (out_valid && out_ready) with O=1.
REQ-019 SHALL saturate true_count at 2^CNT_WIDTH-1 and assert cnt_sat while it equals that value; there is no wrap-around.
REQ-020 SHALL give clear priority over a same-cycle increment: true_count becomes 0 and cnt_sat becomes 0.
REQ-021 SHALL not affect the pipeline contents or handshake when clear is asserted.

Reset
REQ-022 SHALL, on ASYNCRESET high, immediately force both stage valids to 0, out_valid=0, O=0, op_err=0, true_count=0, cnt_sat=0.
REQ-023 SHALL drop in-flight beats on reset mid-operation; after release, in_ready=1 in the first cycle.
REQ-024 SHALL leave stage-1 data registers and stage-2 data registers without functional dependence on reset values beyond REQ-022.

Structure
REQ-025 SHALL keep opcode constants (CMP_EQ..CMP_GE, reserved range) and the 3-bit opcode type in shared package sint_cmp_pkg.
REQ-026 SHALL implement the compare core as combinational sub-module sint_cmp_core (WIDTH, I0, I1, op, is_signed -> O, op_err), instantiated between stage 1 and stage 2.
REQ-027 SHALL contain all state (two pipeline stages, counter) in sint_cmp_pipe only.

Verification (WIDTH=3, CNT_WIDTH=2)
REQ-028 SHALL cover signed LE: I0=3'b111 (-1), I1=3'b001, op=3, is_signed=1 -> O=1 two cycles later; same with is_signed=0 (7 <= 1) -> O=0.
REQ-029 SHALL cover signed extremes: I0=3'b100 (-4), I1=3'b011 (3), op=4 GT, is_signed=1 -> O=0; op=5 GE with I0=I1=3'b100 -> O=1.
REQ-030 SHALL cover back-pressure: 4 back-to-back beats, out_ready low for 3 cycles from the first out_valid -> in_ready falls after 2 accepted, outputs held, all 4 results delivered in order.
REQ-031 SHALL cover reserved opcode: op=6, any operands -> O=0, op_err=1, true_count unchanged.
REQ-032 SHALL cover counter: 5 true-result transfers -> true_count=3, cnt_sat=1; clear asserted coincident with a true transfer -> true_count=0, cnt_sat=0.
REQ-033 SHALL cover reset mid-stream: ASYNCRESET pulsed with 2 beats in flight -> out_valid=0 immediately, no stale result after release, true_count=0.
